// File: rtl/tree_source_route_gen.sv
// Source-route path generator for the K-ary tree NoC.
// Streams the up/down port sequence from src to dst, one hop per beat.
//
// Ports:
//   clk, reset        clock, async active-low reset
//   req_valid/ready   route request handshake (ready only when idle)
//   src_addr/dst_addr endpoint addresses, digit i at [(i+1)*KW-1:i*KW]
//   hop_valid/ready   hop stream handshake
//   hop_port          K = up, 0..K-1 = down
//   hop_idx           zero-based hop number
//   hop_last          final hop (endpoint delivery)
//   self_route        path where src == dst
//   err               one-cycle pulse on illegal digit, request dropped
module tree_source_route_gen #(
    parameter  int K    = 2,
    parameter  int L    = 2,
    localparam int KW   = $clog2(K),
    localparam int LKW  = L * KW,
    localparam int LW   = $clog2(L),
    localparam int DSPW = $clog2(K + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [LKW-1:0]  src_addr,
    input  logic [LKW-1:0]  dst_addr,
    output logic            hop_valid,
    input  logic            hop_ready,
    output logic [DSPW-1:0] hop_port,
    output logic [LW:0]     hop_idx,
    output logic            hop_last,
    output logic            self_route,
    output logic            err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_UP,
        S_DOWN
    } state_t;

    localparam logic [LW-1:0]   LAST   = LW'(L - 1);
    localparam logic [DSPW-1:0] UP_P   = DSPW'(K);
    // Digits can only hold an out-of-range value when K is not 2^n.
    localparam bit              CHK_DG = (K & (K - 1)) != 0;

    state_t           r_state;
    state_t           w_next;
    logic [LKW-1:0]   r_src;
    logic [LKW-1:0]   r_dst;
    logic [LW-1:0]    r_dig;
    logic [LW-1:0]    r_up;
    logic [LW:0]      r_idx;
    logic             r_self;

    logic [LW-1:0]    w_n;
    logic [LW-1:0]    w_up;
    logic             w_bad;
    logic [KW-1:0]    w_dn_dig;

    function automatic logic [KW-1:0] digit(
        input logic [LKW-1:0] a,
        input logic [LW-1:0]  i
    );
        logic [KW-1:0] d;
        d = '0;
        for (int j = 0; j < L; j++) begin
            if (i == LW'(j)) d = a[j*KW +: KW];
        end
        return d;
    endfunction

    // Nearest common ancestor level: first differing digit from the root.
    // Leaf digit never counts, so n = L-1 when the prefixes match.
    always_comb begin
        w_n = LAST;
        for (int j = L - 2; j >= 0; j--) begin
            if (r_src[j*KW +: KW] != r_dst[j*KW +: KW]) w_n = LW'(j);
        end
        w_up = LAST - w_n;
    end

    always_comb begin
        w_bad = 1'b0;
        if (CHK_DG) begin
            for (int j = 0; j < L; j++) begin
                if (int'(r_src[j*KW +: KW]) >= K) w_bad = 1'b1;
                if (int'(r_dst[j*KW +: KW]) >= K) w_bad = 1'b1;
            end
        end
    end

    assign w_dn_dig = digit(r_dst, r_dig);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (req_valid) w_next = S_CALC;
            end
            S_CALC: begin
                if (w_bad)            w_next = S_IDLE;
                else if (w_up != '0)  w_next = S_UP;
                else                  w_next = S_DOWN;
            end
            S_UP: begin
                if (hop_ready && r_up == LW'(1)) w_next = S_DOWN;
            end
            S_DOWN: begin
                if (hop_ready && r_dig == LAST) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Path datapath: captured addresses, hop counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_src  <= '0;
            r_dst  <= '0;
            r_dig  <= '0;
            r_up   <= '0;
            r_idx  <= '0;
            r_self <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_src <= src_addr;
                        r_dst <= dst_addr;
                    end
                end
                S_CALC: begin
                    r_dig  <= w_n;
                    r_up   <= w_up;
                    r_idx  <= '0;
                    r_self <= (r_src == r_dst) && !w_bad;
                end
                S_UP: begin
                    if (hop_ready) begin
                        r_up  <= r_up - LW'(1);
                        r_idx <= r_idx + (LW+1)'(1);
                    end
                end
                S_DOWN: begin
                    if (hop_ready) begin
                        r_idx <= r_idx + (LW+1)'(1);
                        if (r_dig == LAST) r_self <= 1'b0;
                        else               r_dig  <= r_dig + LW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state; all zero outside the hop states
    always_comb begin
        req_ready  = 1'b0;
        hop_valid  = 1'b0;
        hop_port   = '0;
        hop_idx    = '0;
        hop_last   = 1'b0;
        self_route = 1'b0;
        err        = 1'b0;
        unique case (r_state)
            S_IDLE: req_ready = 1'b1;
            S_CALC: err = w_bad;
            S_UP: begin
                hop_valid  = 1'b1;
                hop_port   = UP_P;
                hop_idx    = r_idx;
                self_route = r_self;
            end
            S_DOWN: begin
                hop_valid  = 1'b1;
                hop_port   = DSPW'(w_dn_dig);
                hop_idx    = r_idx;
                hop_last   = (r_dig == LAST);
                self_route = r_self;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tree_source_route_gen.sv
// Bench for tree_source_route_gen: three configurations
// (K=2/L=3, K=4/L=2, K=3/L=2), table vectors, random paths, corner sequences.
module tb_tree_source_route_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int expq[$];

    // DUT A: K=2, L=3
    logic       a_rst_n, a_req_valid, a_req_ready;
    logic [2:0] a_src, a_dst;
    logic       a_hop_valid, a_hop_ready, a_hop_last, a_self, a_err;
    logic [1:0] a_port;
    logic [2:0] a_idx;

    // DUT B: K=4, L=2
    logic       rst_n;
    logic       b_req_valid, b_req_ready;
    logic [3:0] b_src, b_dst;
    logic       b_hop_valid, b_hop_ready, b_hop_last, b_self, b_err;
    logic [2:0] b_port;
    logic [1:0] b_idx;

    // DUT C: K=3, L=2
    logic       c_req_valid, c_req_ready;
    logic [3:0] c_src, c_dst;
    logic       c_hop_valid, c_hop_ready, c_hop_last, c_self, c_err;
    logic [1:0] c_port;
    logic [1:0] c_idx;

    tree_source_route_gen #(.K(2), .L(3)) u_a (
        .clk(clk), .reset(a_rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .src_addr(a_src), .dst_addr(a_dst),
        .hop_valid(a_hop_valid), .hop_ready(a_hop_ready),
        .hop_port(a_port), .hop_idx(a_idx), .hop_last(a_hop_last),
        .self_route(a_self), .err(a_err)
    );

    tree_source_route_gen #(.K(4), .L(2)) u_b (
        .clk(clk), .reset(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .src_addr(b_src), .dst_addr(b_dst),
        .hop_valid(b_hop_valid), .hop_ready(b_hop_ready),
        .hop_port(b_port), .hop_idx(b_idx), .hop_last(b_hop_last),
        .self_route(b_self), .err(b_err)
    );

    tree_source_route_gen #(.K(3), .L(2)) u_c (
        .clk(clk), .reset(rst_n),
        .req_valid(c_req_valid), .req_ready(c_req_ready),
        .src_addr(c_src), .dst_addr(c_dst),
        .hop_valid(c_hop_valid), .hop_ready(c_hop_ready),
        .hop_port(c_port), .hop_idx(c_idx), .hop_last(c_hop_last),
        .self_route(c_self), .err(c_err)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference path: climb to the first differing digit, then descend
    // along the destination digits from that level to the leaf.
    task automatic build_exp(input int k, input int l, input int s, input int d);
        int kw;
        int m;
        int n;
        kw = $clog2(k);
        m  = (1 << kw) - 1;
        n  = l - 1;
        for (int i = 0; i < l - 1; i++) begin
            if (((s >> (i * kw)) & m) != ((d >> (i * kw)) & m)) begin
                n = i;
                break;
            end
        end
        expq.delete();
        for (int i = 0; i < l - 1 - n; i++) expq.push_back(k);
        for (int i = n; i < l; i++) expq.push_back((d >> (i * kw)) & m);
    endtask

    // mode 0: always ready, 1: random ready + busy req noise,
    // 2: ready held low 3 cycles while beat 2 is presented
    task automatic run_a(input int s, input int d, input bit selfx,
                         input int mode, input string nm);
        int k;
        int cyc;
        int stall;
        bit rdy;
        k = 0; cyc = 0; stall = 0;
        chk({nm, "_req_ready"}, int'(a_req_ready), 1);
        a_src = 3'(s); a_dst = 3'(d); a_req_valid = 1'b1;
        @(negedge clk);
        a_req_valid = 1'b0;
        a_src = 3'($urandom); a_dst = 3'($urandom);
        chk({nm, "_calc_valid"}, int'(a_hop_valid), 0);
        chk({nm, "_calc_ready"}, int'(a_req_ready), 0);
        @(negedge clk);
        chk({nm, "_first_T2"}, int'(a_hop_valid), 1);
        while (k < expq.size() && cyc < 200) begin
            case (mode)
                0: rdy = 1'b1;
                1: begin
                    rdy = 1'($urandom_range(0, 1));
                    a_req_valid = 1'($urandom_range(0, 1));
                    a_src = 3'($urandom); a_dst = 3'($urandom);
                end
                default: begin
                    rdy = !(k == 2 && stall < 3);
                    if (!rdy) stall++;
                end
            endcase
            a_hop_ready = rdy;
            chk({nm, "_valid"}, int'(a_hop_valid), 1);
            chk({nm, "_port"}, int'(a_port), expq[k]);
            chk({nm, "_idx"}, int'(a_idx), k);
            chk({nm, "_last"}, int'(a_hop_last), int'(k == expq.size() - 1));
            chk({nm, "_self"}, int'(a_self), int'(selfx));
            chk({nm, "_busy_ready"}, int'(a_req_ready), 0);
            @(negedge clk);
            if (rdy) k++;
            cyc++;
        end
        a_hop_ready = 1'b0;
        a_req_valid = 1'b0;
        chk({nm, "_beats_done"}, k, expq.size());
        if (mode == 2) chk({nm, "_stall_cycles"}, stall, 3);
        chk({nm, "_end_valid"}, int'(a_hop_valid), 0);
        chk({nm, "_end_ready"}, int'(a_req_ready), 1);
        chk({nm, "_end_self"}, int'(a_self), 0);
    endtask

    task automatic run_b(input int s, input int d, input bit selfx, input string nm);
        int k;
        k = 0;
        b_src = 4'(s); b_dst = 4'(d); b_req_valid = 1'b1; b_hop_ready = 1'b1;
        @(negedge clk);
        b_req_valid = 1'b0;
        chk({nm, "_calc_valid"}, int'(b_hop_valid), 0);
        @(negedge clk);
        while (k < expq.size() && k < 8) begin
            chk({nm, "_valid"}, int'(b_hop_valid), 1);
            chk({nm, "_port"}, int'(b_port), expq[k]);
            chk({nm, "_idx"}, int'(b_idx), k);
            chk({nm, "_last"}, int'(b_hop_last), int'(k == expq.size() - 1));
            chk({nm, "_self"}, int'(b_self), int'(selfx));
            @(negedge clk);
            k++;
        end
        b_hop_ready = 1'b0;
        chk({nm, "_end_valid"}, int'(b_hop_valid), 0);
        chk({nm, "_end_ready"}, int'(b_req_ready), 1);
        chk({nm, "_end_self"}, int'(b_self), 0);
    endtask

    typedef struct {
        int src;
        int dst;
        int len;
        int ports[5];
        bit selfr;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int s;
        int d;

        tbl[0] = '{0, 5, 5, '{2, 2, 1, 0, 1}, 1'b0};
        tbl[1] = '{2, 6, 1, '{1, 0, 0, 0, 0}, 1'b0};
        tbl[2] = '{7, 7, 1, '{1, 0, 0, 0, 0}, 1'b1};
        tbl[3] = '{1, 3, 3, '{2, 1, 0, 0, 0}, 1'b0};
        tbl[4] = '{4, 0, 1, '{0, 0, 0, 0, 0}, 1'b0};
        tbl[5] = '{6, 3, 5, '{2, 2, 1, 1, 0}, 1'b0};

        a_rst_n = 1'b0; rst_n = 1'b0;
        a_req_valid = 1'b0; a_src = '0; a_dst = '0; a_hop_ready = 1'b0;
        b_req_valid = 1'b0; b_src = '0; b_dst = '0; b_hop_ready = 1'b0;
        c_req_valid = 1'b0; c_src = '0; c_dst = '0; c_hop_ready = 1'b0;

        #2;
        chk("rst_req_ready", int'(a_req_ready), 1);
        chk("rst_hop_valid", int'(a_hop_valid), 0);
        chk("rst_hop_port", int'(a_port), 0);
        chk("rst_hop_idx", int'(a_idx), 0);
        chk("rst_hop_last", int'(a_hop_last), 0);
        chk("rst_self", int'(a_self), 0);
        chk("rst_err", int'(a_err), 0);
        chk("rst_b_ready", int'(b_req_ready), 1);
        chk("rst_c_err", int'(c_err), 0);

        @(negedge clk);
        a_rst_n = 1'b1; rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", int'(a_req_ready), 1);
        chk("idle_valid", int'(a_hop_valid), 0);

        // Table vectors on K=2, L=3
        for (int i = 0; i < 6; i++) begin
            expq.delete();
            for (int j = 0; j < tbl[i].len; j++) expq.push_back(tbl[i].ports[j]);
            run_a(tbl[i].src, tbl[i].dst, tbl[i].selfr, 0, $sformatf("tbl%0d", i));
        end

        // Backpressure on beat 2 of the long path
        build_exp(2, 3, 0, 5);
        run_a(0, 5, 1'b0, 2, "stall");

        // Random paths with random backpressure
        for (int i = 0; i < 40; i++) begin
            s = $urandom_range(0, 7);
            d = $urandom_range(0, 7);
            build_exp(2, 3, s, d);
            run_a(s, d, s == d, 1, $sformatf("rnd%0d", i));
        end

        // Reset asserted while beat 1 is presented
        a_src = 3'b000; a_dst = 3'b101; a_req_valid = 1'b1;
        @(negedge clk);
        a_req_valid = 1'b0;
        @(negedge clk);
        a_hop_ready = 1'b1;
        @(negedge clk);
        chk("mid_idx_before", int'(a_idx), 1);
        chk("mid_valid_before", int'(a_hop_valid), 1);
        a_rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", int'(a_hop_valid), 0);
        chk("mid_rst_ready", int'(a_req_ready), 1);
        chk("mid_rst_port", int'(a_port), 0);
        chk("mid_rst_idx", int'(a_idx), 0);
        chk("mid_rst_last", int'(a_hop_last), 0);
        chk("mid_rst_self", int'(a_self), 0);
        @(negedge clk);
        a_rst_n = 1'b1;
        a_hop_ready = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", int'(a_hop_valid), 0);
        build_exp(2, 3, 0, 5);
        run_a(0, 5, 1'b0, 0, "rerun");

        // K=4, L=2: self route to endpoint with leaf digit 2
        expq.delete();
        expq.push_back(2);
        run_b(9, 9, 1'b1, "k4_self");
        expq.delete();
        expq.push_back(4); expq.push_back(2); expq.push_back(3);
        run_b(0, 14, 1'b0, "k4_full");
        for (int i = 0; i < 10; i++) begin
            s = $urandom_range(0, 15);
            d = $urandom_range(0, 15);
            build_exp(4, 2, s, d);
            run_b(s, d, s == d, $sformatf("k4rnd%0d", i));
        end

        // K=3, L=2: illegal dst digit 0
        c_hop_ready = 1'b1;
        c_src = 4'b0000; c_dst = 4'b0011; c_req_valid = 1'b1;
        @(negedge clk);
        c_req_valid = 1'b0;
        chk("k3_err_T1", int'(c_err), 1);
        chk("k3_err_T1_valid", int'(c_hop_valid), 0);
        @(negedge clk);
        chk("k3_err_T2", int'(c_err), 0);
        chk("k3_err_T2_ready", int'(c_req_ready), 1);
        chk("k3_err_T2_valid", int'(c_hop_valid), 0);
        @(negedge clk);
        chk("k3_err_T3_valid", int'(c_hop_valid), 0);

        // K=3, L=2: illegal src leaf digit
        c_src = 4'b1100; c_dst = 4'b0000; c_req_valid = 1'b1;
        @(negedge clk);
        c_req_valid = 1'b0;
        chk("k3_srcerr", int'(c_err), 1);
        @(negedge clk);
        chk("k3_srcerr_ready", int'(c_req_ready), 1);

        // K=3, L=2: legal sibling route, single down hop
        c_src = 4'b0010; c_dst = 4'b0110; c_req_valid = 1'b1;
        @(negedge clk);
        c_req_valid = 1'b0;
        chk("k3_ok_err", int'(c_err), 0);
        @(negedge clk);
        chk("k3_ok_valid", int'(c_hop_valid), 1);
        chk("k3_ok_port", int'(c_port), 1);
        chk("k3_ok_idx", int'(c_idx), 0);
        chk("k3_ok_last", int'(c_hop_last), 1);
        chk("k3_ok_self", int'(c_self), 0);
        @(negedge clk);
        chk("k3_ok_end", int'(c_hop_valid), 0);
        chk("k3_ok_ready", int'(c_req_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
